// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master, three-slave bus arbiter with registered outputs,
//               round-robin or fixed priority, and optional grant watchdog
//               (enabled by defining ARB_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic [1:0] m1_addr_hi,
    input  logic [1:0] m2_addr_hi,
    input  logic       tx_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       mux_sel,
    output logic [2:0] slave_sel,
    output logic       busy,
    output logic       addr_err,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_M1 = 2'd1,
        ST_GRANT_M2 = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_m2;
    logic       w_last_m2_nxt;
    logic       r_mux_sel;
    logic       w_mux_sel_nxt;
    logic [2:0] r_slave_sel;
    logic [2:0] w_slave_sel_nxt;
    logic       r_addr_err;
    logic       w_addr_err_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic       r_m1_grant;
    logic       r_m2_grant;
    logic       r_busy;
    logic       w_pick_m2;
    logic [1:0] w_addr;
    logic       w_owner_req;
    logic       w_expire;
    logic       w_wdog_clr;
    logic       w_wdog_inc;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wdog;

    // Counter value equals the number of grant cycles already completed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= 8'd0;
        end else if (w_wdog_clr) begin
            r_wdog <= 8'd0;
        end else if (w_wdog_inc) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    assign w_expire = (r_wdog == c_TIMEOUT_LAST);
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_last_m2_nxt   = r_last_m2;
        w_mux_sel_nxt   = r_mux_sel;
        w_slave_sel_nxt = r_slave_sel;
        w_addr_err_nxt  = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_wdog_clr      = 1'b0;
        w_wdog_inc      = 1'b0;
        w_pick_m2       = 1'b0;
        w_addr          = 2'b00;
        w_owner_req     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (m1_req && m2_req) begin
                    w_pick_m2 = (ROUND_ROBIN != 0) ? !r_last_m2 : 1'b0;
                end else begin
                    w_pick_m2 = m2_req;
                end
                w_addr = w_pick_m2 ? m2_addr_hi : m1_addr_hi;
                if (m1_req || m2_req) begin
                    w_last_m2_nxt = w_pick_m2;
                    if (w_addr == 2'b11) begin
                        // Unmapped window: burn the decision and go through RELEASE.
                        w_addr_err_nxt  = 1'b1;
                        w_slave_sel_nxt = 3'b000;
                        w_state_nxt     = ST_RELEASE;
                    end else begin
                        w_mux_sel_nxt   = w_pick_m2;
                        w_slave_sel_nxt = 3'b001 << w_addr;
                        w_wdog_clr      = 1'b1;
                        w_state_nxt     = w_pick_m2 ? ST_GRANT_M2 : ST_GRANT_M1;
                    end
                end
            end
            ST_GRANT_M1, ST_GRANT_M2: begin
                w_owner_req = (r_state == ST_GRANT_M1) ? m1_req : m2_req;
                if (tx_done || !w_owner_req) begin
                    w_slave_sel_nxt = 3'b000;
                    w_state_nxt     = ST_RELEASE;
                end else if (w_expire) begin
                    w_timeout_nxt   = 1'b1;
                    w_slave_sel_nxt = 3'b000;
                    w_state_nxt     = ST_RELEASE;
                end else begin
                    w_wdog_inc = 1'b1;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last_m2   <= 1'b1;
            r_mux_sel   <= 1'b0;
            r_slave_sel <= 3'b000;
            r_addr_err  <= 1'b0;
            r_timeout   <= 1'b0;
            r_m1_grant  <= 1'b0;
            r_m2_grant  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_m2   <= w_last_m2_nxt;
            r_mux_sel   <= w_mux_sel_nxt;
            r_slave_sel <= w_slave_sel_nxt;
            r_addr_err  <= w_addr_err_nxt;
            r_timeout   <= w_timeout_nxt;
            r_m1_grant  <= (w_state_nxt == ST_GRANT_M1);
            r_m2_grant  <= (w_state_nxt == ST_GRANT_M2);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign m1_grant  = r_m1_grant;
    assign m2_grant  = r_m2_grant;
    assign mux_sel   = r_mux_sel;
    assign slave_sel = r_slave_sel;
    assign busy      = r_busy;
    assign addr_err  = r_addr_err;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter; drives a round-robin and
//               a fixed-priority instance from shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int c_TMO = 8;
    localparam bit c_TEN = 1'b1;
`else
    localparam int c_TMO = 64;
    localparam bit c_TEN = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       m1_req     = 1'b0;
    logic       m2_req     = 1'b0;
    logic [1:0] m1_addr_hi = 2'b00;
    logic [1:0] m2_addr_hi = 2'b00;
    logic       tx_done    = 1'b0;

    logic [1:0] g1, g2, mux, busy, aerr, tmo;
    logic [5:0] ssel;

    int total = 0;
    int bad   = 0;

    // Reference state: index 0 = round-robin instance, 1 = fixed priority.
    int         own  [2];
    int         last [2];
    int         cnt  [2];
    bit         rel  [2];
    bit         e_err[2];
    bit         e_to [2];
    bit         e_mux[2];
    logic [2:0] e_slave[2];

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(c_TMO), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(reset), .m1_req(m1_req), .m2_req(m2_req),
        .m1_addr_hi(m1_addr_hi), .m2_addr_hi(m2_addr_hi), .tx_done(tx_done),
        .m1_grant(g1[0]), .m2_grant(g2[0]), .mux_sel(mux[0]),
        .slave_sel(ssel[2:0]), .busy(busy[0]), .addr_err(aerr[0]), .timeout(tmo[0])
    );

    bus_arbiter #(.TIMEOUT_CYCLES(c_TMO), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .reset(reset), .m1_req(m1_req), .m2_req(m2_req),
        .m1_addr_hi(m1_addr_hi), .m2_addr_hi(m2_addr_hi), .tx_done(tx_done),
        .m1_grant(g1[1]), .m2_grant(g2[1]), .mux_sel(mux[1]),
        .slave_sel(ssel[5:3]), .busy(busy[1]), .addr_err(aerr[1]), .timeout(tmo[1])
    );

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[inst%0d]: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; last[k] = 2; cnt[k] = 0; rel[k] = 1'b0;
            e_err[k] = 1'b0; e_to[k] = 1'b0; e_mux[k] = 1'b0; e_slave[k] = 3'b000;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int       pick;
            bit       done;
            bit       expd;
            bit [1:0] a;
            e_err[k] = 1'b0;
            e_to[k]  = 1'b0;
            if (own[k] != 0) begin
                done = tx_done || !((own[k] == 1) ? m1_req : m2_req);
                expd = c_TEN && !done && (cnt[k] + 1 == c_TMO);
                if (done || expd) begin
                    own[k] = 0; rel[k] = 1'b1; e_to[k] = expd;
                end else begin
                    cnt[k]++;
                end
            end else if (rel[k]) begin
                rel[k] = 1'b0;
            end else begin
                pick = 0;
                if (m1_req && m2_req) pick = (k == 0) ? ((last[k] == 1) ? 2 : 1) : 1;
                else if (m1_req)      pick = 1;
                else if (m2_req)      pick = 2;
                if (pick != 0) begin
                    last[k] = pick;
                    a = (pick == 1) ? m1_addr_hi : m2_addr_hi;
                    if (a == 2'b11) begin
                        rel[k] = 1'b1; e_err[k] = 1'b1;
                    end else begin
                        own[k] = pick; cnt[k] = 0;
                        e_slave[k] = 3'b001 << a;
                        e_mux[k] = (pick == 2);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [2:0] s;
            s = (k == 0) ? ssel[2:0] : ssel[5:3];
            chk("m1_grant",  k, 8'(g1[k]),   8'(own[k] == 1));
            chk("m2_grant",  k, 8'(g2[k]),   8'(own[k] == 2));
            chk("busy",      k, 8'(busy[k]), 8'((own[k] != 0) || rel[k]));
            chk("slave_sel", k, 8'(s),       8'((own[k] != 0) ? e_slave[k] : 3'b000));
            chk("addr_err",  k, 8'(aerr[k]), 8'(e_err[k]));
            chk("timeout",   k, 8'(tmo[k]),  8'(e_to[k]));
            if (own[k] != 0) chk("mux_sel", k, 8'(mux[k]), 8'(e_mux[k]));
            chk("both_grants",  k, 8'(g1[k] & g2[k]), 8'd0);
            chk("slave_onehot", k, 8'(s & 3'(s - 3'd1)), 8'd0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step();
        #1;
        check_all();
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        cycle();
        tx_done = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b0;
        #1;
        check_all();
        for (int k = 0; k < 2; k++) chk("reset_mux", k, 8'(mux[k]), 8'd0);
        cycle();

        // Single m1 transaction to slave1, completed by tx_done.
        m1_req = 1'b1; m1_addr_hi = 2'b01;
        @(negedge clk) reset = 1'b1;
        cycle();
        chk("first_grant_slave", 0, 8'(ssel[2:0]), 8'b010);
        repeat (4) cycle();
        pulse_done();
        m1_req = 1'b0;
        repeat (3) cycle();

        // Simultaneous requests, repeated completions.
        m1_addr_hi = 2'b00; m2_addr_hi = 2'b10;
        m1_req = 1'b1; m2_req = 1'b1;
        repeat (5) begin
            repeat (3) cycle();
            pulse_done();
        end
        m1_req = 1'b0; m2_req = 1'b0;
        repeat (3) cycle();

        // Unmapped address from m2.
        m2_req = 1'b1; m2_addr_hi = 2'b11;
        repeat (2) cycle();
        m2_req = 1'b0;
        repeat (3) cycle();

        // Long hold without completion.
        m1_req = 1'b1; m1_addr_hi = 2'b10;
        repeat (110) cycle();
        m1_req = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset in the middle of an m2 grant.
        m2_req = 1'b1; m2_addr_hi = 2'b10;
        repeat (4) cycle();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_m2_grant", k, 8'(g2[k]), 8'd0);
            chk("async_busy",     k, 8'(busy[k]), 8'd0);
        end
        model_reset();
        check_all();
        m1_req = 1'b1; m1_addr_hi = 2'b00;
        @(negedge clk) reset = 1'b1;
        cycle();
        chk("post_reset_m1_wins", 0, 8'(g1[0]), 8'd1);
        repeat (2) cycle();
        pulse_done();
        m1_req = 1'b0; m2_req = 1'b0;
        repeat (3) cycle();

        // Randomized traffic.
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
            if ($urandom_range(0, 7) == 0) m2_req = ~m2_req;
            if ($urandom_range(0, 3) == 0) m1_addr_hi = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) m2_addr_hi = 2'($urandom_range(0, 3));
            tx_done = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
